prbs_pattern_engine: RTL and testbench
======================================

// Module: prbs_pattern_engine
// PURPOSE
//   Parametrised successor of the fixed 8-bit PRBS pattern detector. Captures a PAT_WORDS-word
//   reference pattern from the seq stream and counts back-to-back repeats of it. After N matched
//   repetitions it raises Pattern_Flag and streams PRBS words seeded from the pattern.
//   The PRBS polynomial is run-time selectable (PRBS7/15/31). Sits between the serial test
//   source and the link-under-test.
// PARAMETERS
//   DATA_W     8   width of seq/OUT words; legal 1..32
//   PAT_WORDS  4   words per reference pattern; PAT_WORDS*DATA_W must be >= 31
//   CNT_W      8   width of N and rep_cnt
// PORTS
//   clk           in   1          clock, all state on rising edge
//   rst           in   1          asynchronous, active-high reset
//   start         in   1          1-cycle pulse: sample N/mode, (re)enter CAPTURE
//   N             in   CNT_W      required repetition count, sampled on start
//   mode          in   2          00 PRBS7 (x^7+x^6+1), 01 PRBS15 (x^15+x^14+1),
//                                 10 PRBS31 (x^31+x^28+1), 11 treated as 01; sampled on start
//   seq           in   DATA_W     input word stream
//   seq_valid     in   1          seq is sampled only when high
//   OUT           out  DATA_W     PRBS output word, 0 when out_valid=0
//   out_valid     out  1          OUT carries a PRBS word this cycle
//   Pattern_Flag  out  1          N repetitions detected; sticky until start/rst
//   rep_cnt       out  CNT_W      completed matched repetitions (saturates at N)
//   busy          out  1          high in CAPTURE/DETECT
// BEHAVIOUR
//   Reset (async): state=IDLE; OUT=0, out_valid=0, Pattern_Flag=0, rep_cnt=0, busy=0,
//     pattern regs=0, word index=0, LFSR=0.
//   FSM: IDLE -start-> CAPTURE -PAT_WORDS valid words-> DETECT -rep_cnt==N-> PRBS.
//     start in any state => CAPTURE next edge; clears flag, rep_cnt, index, out_valid. start has priority.
//   CAPTURE: each seq_valid word stored at pat[idx], idx++. On the last word rep_cnt<=1.
//     If N<=1, go straight to PRBS on that edge; otherwise go to DETECT with idx=0.
//   DETECT: each valid word compared with pat[idx]. Match => idx++ (wraps at PAT_WORDS).
//     On wrap rep_cnt++; at rep_cnt+1==N go to PRBS.
//     Mismatch => rep_cnt<=0, idx<=0; the mismatching word is not re-evaluated as word 0.
//     After a mismatch, N full fresh matches are required.
//   seq_valid=0 cycles: no state change in CAPTURE/DETECT (gaps are transparent).
//   PRBS entry edge: Pattern_Flag<=1, busy<=0.
//     LFSR loaded with seed = low L bits of {pat[0],pat[1],..,pat[PAT_WORDS-1]} (pat[0] in MSBs),
//     L=7/15/31 per mode. All-zero seed is forced to all ones.
//   PRBS: every cycle advance LFSR DATA_W steps. Step k: b=lfsr[L-1]^lfsr[T-1] (T=6/14/28);
//     lfsr={lfsr[L-2:0],b}; OUT[k]=b (k=0 first step). OUT/out_valid are registered.
//     The first out_valid is 1 cycle after Pattern_Flag rises, then continuous every cycle until start/rst.
//   Latency: Pattern_Flag rises on the edge sampling the last word of repetition N (1 clk after presentation).
//   seq ignored in IDLE and PRBS. N and mode changes mid-run have no effect until the next start.
//   rep_cnt arithmetic CNT_W-bit, never exceeds N. N=0 behaves as N=1.
// TESTING (DATA_W=8, PAT_WORDS=4, CNT_W=8)
//   1. start N=5 mode=01, feed AB,CD,EF,23 x5 back-to-back -> flag 1 clk after 20th word, rep_cnt=5,
//      out_valid next clk.
//   2. start N=3, feed AB,CD,EF,23 then AB,BD,EF,23 -> rep_cnt 0 at word 6, flag stays 0;
//      then 3 clean reps -> flag=1.
//   3. start N=1 mode=00, feed 00,00,00,00 -> seed forced 7'h7F; OUT words 0x40 then 0x30.
//   4. Case 1 with seq_valid low every other cycle -> same flag result, rep_cnt identical per word.
//   5. rst pulsed mid-PRBS (async, between edges) -> OUT=0, out_valid=0, flag=0 immediately.
//   6. start pulsed during PRBS -> next edge out_valid=0, flag=0, busy=1; a new capture proceeds normally.

Source files
------------

// File: rtl/prbs_pattern_engine.sv
// prbs_pattern_engine: captures a PAT_WORDS-word reference pattern from the seq
// stream, counts back-to-back repeats of it, and after N repeats raises a sticky
// flag and streams PRBS7/15/31 words seeded from the captured pattern.
module prbs_pattern_engine #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PAT_WORDS = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  N,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seq,
    input  logic              seq_valid,
    output logic [DATA_W-1:0] OUT,
    output logic              out_valid,
    output logic              Pattern_Flag,
    output logic [CNT_W-1:0]  rep_cnt,
    output logic              busy
);

    localparam int unsigned IDX_W    = (PAT_WORDS > 1) ? $clog2(PAT_WORDS) : 1;
    localparam int unsigned PAT_BITS = PAT_WORDS * DATA_W;
    localparam int unsigned LFSR_W   = 31;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_CAPTURE = 2'b01,
        S_DETECT  = 2'b10,
        S_PRBS    = 2'b11
    } state_t;

    // Active-length mask of the shared 31-bit LFSR; mode 11 aliases PRBS15.
    function automatic logic [LFSR_W-1:0] len_mask(input logic [1:0] m);
        case (m)
            2'b00:   len_mask = 31'h0000_007F;
            2'b10:   len_mask = 31'h7FFF_FFFF;
            default: len_mask = 31'h0000_7FFF;
        endcase
    endfunction

    // Feedback bit: lfsr[L-1] ^ lfsr[T-1] for the selected polynomial.
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s, input logic [1:0] m);
        case (m)
            2'b00:   lfsr_fb = s[6]  ^ s[5];
            2'b10:   lfsr_fb = s[30] ^ s[27];
            default: lfsr_fb = s[14] ^ s[13];
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    rep_cnt_q, rep_cnt_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [1:0]          mode_q, mode_d;
    logic                flag_q, flag_d;
    logic                busy_q, busy_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   pat_q [PAT_WORDS];
    logic [DATA_W-1:0]   pat_d [PAT_WORDS];

    logic [LFSR_W-1:0]   step_lfsr;
    logic [DATA_W-1:0]   step_word;
    logic                step_fb;
    logic [PAT_BITS-1:0] pat_cat;
    logic [LFSR_W-1:0]   seed_raw;
    logic [LFSR_W-1:0]   seed;
    logic                enter_prbs;

    // Pattern register write: the current word lands at pat[idx] while capturing.
    always_comb begin
        for (int i = 0; i < int'(PAT_WORDS); i++) begin
            pat_d[i] = pat_q[i];
        end
        if (!start && (state_q == S_CAPTURE) && seq_valid) begin
            pat_d[idx_q] = seq;
        end
    end

    // Seed: low L bits of the pattern with pat[0] in the MSBs; all-zero forced to all ones.
    always_comb begin
        pat_cat = '0;
        for (int i = 0; i < int'(PAT_WORDS); i++) begin
            pat_cat[(int'(PAT_WORDS) - 1 - i) * int'(DATA_W) +: DATA_W] = pat_d[i];
        end
        seed_raw = pat_cat[LFSR_W-1:0] & len_mask(mode_q);
        seed     = (seed_raw == '0) ? len_mask(mode_q) : seed_raw;
    end

    // One output word: DATA_W LFSR steps, first step lands in OUT[0].
    always_comb begin
        step_lfsr = lfsr_q;
        step_word = '0;
        step_fb   = 1'b0;
        for (int k = 0; k < int'(DATA_W); k++) begin
            step_fb      = lfsr_fb(step_lfsr, mode_q);
            step_word[k] = step_fb;
            step_lfsr    = {step_lfsr[LFSR_W-2:0], step_fb} & len_mask(mode_q);
        end
    end

    // Next-state and registered-output logic; start overrides every state.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rep_cnt_d   = rep_cnt_q;
        n_d         = n_q;
        mode_d      = mode_q;
        flag_d      = flag_q;
        lfsr_d      = lfsr_q;
        out_d       = '0;
        out_valid_d = 1'b0;
        enter_prbs  = 1'b0;

        if (start) begin
            state_d   = S_CAPTURE;
            idx_d     = '0;
            rep_cnt_d = '0;
            flag_d    = 1'b0;
            n_d       = N;
            mode_d    = mode;
        end else begin
            case (state_q)
                S_CAPTURE: begin
                    if (seq_valid) begin
                        if (idx_q == LAST_IDX) begin
                            idx_d     = '0;
                            rep_cnt_d = CNT_W'(1);
                            // N of 0 or 1 is already satisfied by the captured copy
                            if (n_q <= CNT_W'(1)) begin
                                enter_prbs = 1'b1;
                            end else begin
                                state_d = S_DETECT;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                S_DETECT: begin
                    if (seq_valid) begin
                        if (seq == pat_q[idx_q]) begin
                            if (idx_q == LAST_IDX) begin
                                idx_d     = '0;
                                rep_cnt_d = rep_cnt_q + CNT_W'(1);
                                if (rep_cnt_d == n_q) begin
                                    enter_prbs = 1'b1;
                                end
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end else begin
                            // mismatching word is dropped, not retried as word 0
                            idx_d     = '0;
                            rep_cnt_d = '0;
                        end
                    end
                end
                S_PRBS: begin
                    lfsr_d      = step_lfsr;
                    out_d       = step_word;
                    out_valid_d = 1'b1;
                end
                default: begin
                end
            endcase

            if (enter_prbs) begin
                state_d = S_PRBS;
                flag_d  = 1'b1;
                lfsr_d  = seed;
            end
        end

        busy_d = (state_d == S_CAPTURE) || (state_d == S_DETECT);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rep_cnt_q   <= '0;
            n_q         <= '0;
            mode_q      <= '0;
            flag_q      <= 1'b0;
            busy_q      <= 1'b0;
            lfsr_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < int'(PAT_WORDS); i++) begin
                pat_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rep_cnt_q   <= rep_cnt_d;
            n_q         <= n_d;
            mode_q      <= mode_d;
            flag_q      <= flag_d;
            busy_q      <= busy_d;
            lfsr_q      <= lfsr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < int'(PAT_WORDS); i++) begin
                pat_q[i] <= pat_d[i];
            end
        end
    end

    assign OUT          = out_q;
    assign out_valid    = out_valid_q;
    assign Pattern_Flag = flag_q;
    assign rep_cnt      = rep_cnt_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_prbs_pattern_engine.sv
// tb_prbs_pattern_engine: directed vector table plus hand-written multi-cycle
// sequences for the PRBS pattern engine (DATA_W=8, PAT_WORDS=4, CNT_W=8).
module tb_prbs_pattern_engine;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned PAT_WORDS = 4;
    localparam int unsigned CNT_W     = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  N = '0;
    logic [1:0]        mode = '0;
    logic [DATA_W-1:0] seq = '0;
    logic              seq_valid = 1'b0;
    logic [DATA_W-1:0] OUT;
    logic              out_valid;
    logic              Pattern_Flag;
    logic [CNT_W-1:0]  rep_cnt;
    logic              busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Independent PRBS reference: bit history with b[n] = b[n-L] ^ b[n-T].
    bit hist [0:1023];
    int hlen;

    typedef struct {
        logic       st;
        logic [7:0] n;
        logic [1:0] m;
        logic [7:0] s;
        logic       v;
        logic       e_flag;
        logic [7:0] e_rep;
        logic       e_busy;
        logic       e_ov;
        logic [7:0] e_out;
        logic       chk_out;
    } vec_t;

    localparam int NV = 29;
    vec_t tbl [NV];

    prbs_pattern_engine #(
        .DATA_W   (DATA_W),
        .PAT_WORDS(PAT_WORDS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .N           (N),
        .mode        (mode),
        .seq         (seq),
        .seq_valid   (seq_valid),
        .OUT         (OUT),
        .out_valid   (out_valid),
        .Pattern_Flag(Pattern_Flag),
        .rep_cnt     (rep_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return 1ns after the rising edge.
    task automatic step(input logic st, input logic [7:0] n, input logic [1:0] m,
                        input logic [7:0] s, input logic v);
        @(negedge clk);
        start     = st;
        N         = n;
        mode      = m;
        seq       = s;
        seq_valid = v;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic model_seed(input logic [31:0] sd, input int L);
        for (int i = 0; i < L; i++) begin
            hist[i] = sd[L-1-i];
        end
        hlen = L;
    endtask

    task automatic model_word(input int L, input int T, output logic [7:0] w);
        w = '0;
        for (int k = 0; k < 8; k++) begin
            hist[hlen] = hist[hlen-L] ^ hist[hlen-T];
            w[k]       = hist[hlen];
            hlen++;
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [7:0] n, input logic [1:0] m,
                                input logic [7:0] s, input logic v, input logic e_flag,
                                input logic [7:0] e_rep, input logic e_busy, input logic e_ov,
                                input logic [7:0] e_out, input logic chk_out);
        vec_t r;
        r.st = st; r.n = n; r.m = m; r.s = s; r.v = v;
        r.e_flag = e_flag; r.e_rep = e_rep; r.e_busy = e_busy; r.e_ov = e_ov;
        r.e_out = e_out; r.chk_out = chk_out;
        return r;
    endfunction

    // Pattern AB,CD,EF,23 repeated N=5 times, optionally with a seq_valid gap after each word.
    task automatic run_case1(input bit gap, input string tag);
        logic [7:0] pat [4];
        logic [7:0] ew;
        pat = '{8'hAB, 8'hCD, 8'hEF, 8'h23};
        step(1'b1, 8'd5, 2'b01, 8'h00, 1'b0);
        check($sformatf("%s start busy", tag), busy, 1);
        check($sformatf("%s start rep", tag), rep_cnt, 0);
        check($sformatf("%s start flag", tag), Pattern_Flag, 0);
        for (int w = 1; w <= 20; w++) begin
            step(1'b0, 8'd5, 2'b01, pat[(w-1)%4], 1'b1);
            check($sformatf("%s rep w%0d", tag, w), rep_cnt, w / 4);
            check($sformatf("%s flag w%0d", tag, w), Pattern_Flag, (w == 20));
            if (gap && w < 20) begin
                step(1'b0, 8'd5, 2'b01, 8'h5A, 1'b0);
                check($sformatf("%s gap rep w%0d", tag, w), rep_cnt, w / 4);
                check($sformatf("%s gap flag w%0d", tag, w), Pattern_Flag, 0);
            end
        end
        check($sformatf("%s entry busy", tag), busy, 0);
        check($sformatf("%s entry out_valid", tag), out_valid, 0);
        check($sformatf("%s entry OUT", tag), OUT, 0);
        // seed = low 15 bits of ABCDEF23 = 6F23
        model_seed(32'h0000_6F23, 15);
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 8'd5, 2'b01, 8'h00, 1'b1);
            model_word(15, 14, ew);
            check($sformatf("%s prbs ov%0d", tag, j), out_valid, 1);
            check($sformatf("%s prbs word%0d", tag, j), OUT, ew);
            check($sformatf("%s prbs rep%0d", tag, j), rep_cnt, 5);
        end
    endtask

    initial begin
        logic [7:0] ew;

        // Test 2 (N=3, mismatch then 3 clean reps) and test 3 (N=1 PRBS7, zero seed)
        tbl[0]  = mk(1, 3, 2'b01, 8'h00, 0,  0, 0, 1, 0, 8'h00, 1);
        tbl[1]  = mk(0, 3, 2'b01, 8'hAB, 1,  0, 0, 1, 0, 8'h00, 1);
        tbl[2]  = mk(0, 3, 2'b01, 8'hCD, 1,  0, 0, 1, 0, 8'h00, 1);
        tbl[3]  = mk(0, 3, 2'b01, 8'hEF, 1,  0, 0, 1, 0, 8'h00, 1);
        tbl[4]  = mk(0, 3, 2'b01, 8'h23, 1,  0, 1, 1, 0, 8'h00, 1);
        tbl[5]  = mk(0, 3, 2'b01, 8'hAB, 1,  0, 1, 1, 0, 8'h00, 1);
        tbl[6]  = mk(0, 3, 2'b01, 8'hBD, 1,  0, 0, 1, 0, 8'h00, 1);
        tbl[7]  = mk(0, 3, 2'b01, 8'hEF, 1,  0, 0, 1, 0, 8'h00, 1);
        tbl[8]  = mk(0, 3, 2'b01, 8'h23, 1,  0, 0, 1, 0, 8'h00, 1);
        tbl[9]  = mk(0, 3, 2'b01, 8'hAB, 1,  0, 0, 1, 0, 8'h00, 1);
        tbl[10] = mk(0, 3, 2'b01, 8'hCD, 1,  0, 0, 1, 0, 8'h00, 1);
        tbl[11] = mk(0, 3, 2'b01, 8'hEF, 1,  0, 0, 1, 0, 8'h00, 1);
        tbl[12] = mk(0, 3, 2'b01, 8'h23, 1,  0, 1, 1, 0, 8'h00, 1);
        tbl[13] = mk(0, 3, 2'b01, 8'hAB, 1,  0, 1, 1, 0, 8'h00, 1);
        tbl[14] = mk(0, 3, 2'b01, 8'hCD, 1,  0, 1, 1, 0, 8'h00, 1);
        tbl[15] = mk(0, 3, 2'b01, 8'hEF, 1,  0, 1, 1, 0, 8'h00, 1);
        tbl[16] = mk(0, 3, 2'b01, 8'h23, 1,  0, 2, 1, 0, 8'h00, 1);
        tbl[17] = mk(0, 3, 2'b01, 8'hAB, 1,  0, 2, 1, 0, 8'h00, 1);
        tbl[18] = mk(0, 3, 2'b01, 8'hCD, 1,  0, 2, 1, 0, 8'h00, 1);
        tbl[19] = mk(0, 3, 2'b01, 8'hEF, 1,  0, 2, 1, 0, 8'h00, 1);
        tbl[20] = mk(0, 3, 2'b01, 8'h23, 1,  1, 3, 0, 0, 8'h00, 1);
        tbl[21] = mk(0, 3, 2'b01, 8'h00, 0,  1, 3, 0, 1, 8'h00, 0);
        tbl[22] = mk(1, 1, 2'b00, 8'h00, 0,  0, 0, 1, 0, 8'h00, 1);
        tbl[23] = mk(0, 1, 2'b00, 8'h00, 1,  0, 0, 1, 0, 8'h00, 1);
        tbl[24] = mk(0, 1, 2'b00, 8'h00, 1,  0, 0, 1, 0, 8'h00, 1);
        tbl[25] = mk(0, 1, 2'b00, 8'h00, 1,  0, 0, 1, 0, 8'h00, 1);
        tbl[26] = mk(0, 1, 2'b00, 8'h00, 1,  1, 1, 0, 0, 8'h00, 1);
        tbl[27] = mk(0, 1, 2'b00, 8'hAA, 0,  1, 1, 0, 1, 8'h40, 1);
        tbl[28] = mk(0, 1, 2'b00, 8'hAA, 0,  1, 1, 0, 1, 8'h30, 1);

        // Reset state while rst is held
        #12;
        check("reset OUT", OUT, 0);
        check("reset out_valid", out_valid, 0);
        check("reset flag", Pattern_Flag, 0);
        check("reset rep_cnt", rep_cnt, 0);
        check("reset busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // seq ignored in IDLE
        step(1'b0, 8'd1, 2'b00, 8'hAB, 1'b1);
        step(1'b0, 8'd1, 2'b00, 8'hCD, 1'b1);
        check("idle busy", busy, 0);
        check("idle rep", rep_cnt, 0);
        check("idle flag", Pattern_Flag, 0);

        // Test 1: five back-to-back repetitions, PRBS15
        run_case1(1'b0, "t1");

        // Test 5: async reset between edges while streaming
        step(1'b0, 8'd5, 2'b01, 8'h00, 1'b0);
        check("t5 pre ov", out_valid, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5 async OUT", OUT, 0);
        check("t5 async out_valid", out_valid, 0);
        check("t5 async flag", Pattern_Flag, 0);
        check("t5 async rep", rep_cnt, 0);
        check("t5 async busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Tests 2 and 3 from the vector table
        for (int i = 0; i < NV; i++) begin
            step(tbl[i].st, tbl[i].n, tbl[i].m, tbl[i].s, tbl[i].v);
            check($sformatf("vec%0d flag", i), Pattern_Flag, tbl[i].e_flag);
            check($sformatf("vec%0d rep", i), rep_cnt, tbl[i].e_rep);
            check($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
            check($sformatf("vec%0d out_valid", i), out_valid, tbl[i].e_ov);
            if (tbl[i].chk_out) begin
                check($sformatf("vec%0d OUT", i), OUT, tbl[i].e_out);
            end
        end

        // Test 4: case 1 with seq_valid low every other cycle
        run_case1(1'b1, "t4");

        // Test 6: start during PRBS, then a fresh PRBS31 run with N=2;
        // N/mode inputs are wiggled mid-run and must be ignored.
        step(1'b1, 8'd2, 2'b10, 8'h00, 1'b0);
        check("t6 start ov", out_valid, 0);
        check("t6 start OUT", OUT, 0);
        check("t6 start flag", Pattern_Flag, 0);
        check("t6 start busy", busy, 1);
        check("t6 start rep", rep_cnt, 0);
        for (int r = 0; r < 2; r++) begin
            step(1'b0, 8'd9, 2'b00, 8'h12, 1'b1);
            step(1'b0, 8'd9, 2'b00, 8'h34, 1'b1);
            step(1'b0, 8'd9, 2'b00, 8'h56, 1'b1);
            step(1'b0, 8'd9, 2'b00, 8'h78, 1'b1);
            check($sformatf("t6 rep r%0d", r), rep_cnt, r + 1);
            check($sformatf("t6 flag r%0d", r), Pattern_Flag, (r == 1));
            check($sformatf("t6 busy r%0d", r), busy, (r == 0));
        end
        model_seed(32'h1234_5678, 31);
        for (int j = 0; j < 2; j++) begin
            step(1'b0, 8'd9, 2'b00, 8'h00, 1'b1);
            model_word(31, 28, ew);
            check($sformatf("t6 prbs ov%0d", j), out_valid, 1);
            check($sformatf("t6 prbs word%0d", j), OUT, ew);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
